fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Generates the 2-bit operand-select codes for the EX-stage 3:1 operand muxes, using the mux encoding: 0 = ID/EX register-file value, 1 = EX/MEM result, 2 = MEM/WB result.
- Detects load-use hazards and raises a stall to hold IF/ID and insert a bubble into EX.
- Keeps its own shadow pipeline of register-destination info for the EX, MEM and WB stages, and counts stall cycles.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_ADDR_W  ID source register A.
- id_rt  in  REG_ADDR_W  ID source register B.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  kill the ID instruction (taken branch/jump).
- fwd_a_sel  out  2  select for EX operand A mux.
- fwd_b_sel  out  2  select for EX operand B mux.
- stall  out  1  hold PC and IF/ID; bubble into EX.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow stages EX, MEM, WB. Each holds: valid, rs, rt, uses_rs, uses_rt, rd, reg_write, mem_read.
- Every rising edge: WB<=MEM, MEM<=EX.
- EX loads the ID fields, unless stall=1 or flush=1. In that case EX loads a bubble: valid=0, reg_write=0, mem_read=0.
- flush has priority over stall for the bubble.
- The caller holds the ID inputs stable while stall=1.
- Reset (asynchronous, any time, including mid-stall):
  - all stage valid/reg_write/mem_read = 0;
  - stall_count = 0;
  - outputs therefore fwd_a_sel = 0, fwd_b_sel = 0, stall = 0.
  - Operation resumes on the first edge after rst_n rises.
- Producer match: stage S "produces r" if S.valid && S.reg_write && S.rd == r && r != 0.
- fwd_a_sel (combinational from registered state):
  - 0 if !EX.valid or !EX.uses_rs;
  - else 1 if MEM produces EX.rs;
  - else 2 if WB produces EX.rs;
  - else 0.
  - The MEM match has priority over the WB match (newest value wins).
  - fwd_b_sel is the same rule using EX.rt/uses_rt.
  - Code 3 is never driven.
- Load in MEM matching an EX source cannot occur, because the stall prevents it. If it does occur anyway, the output is still code 1. No special handling.
- stall (combinational):
  - 1 when id_valid && !flush && EX.valid && EX.mem_read && EX.rd != 0 && ((id_uses_rs && id_rs == EX.rd) || (id_uses_rt && id_rt == EX.rd)).
  - The stall lasts exactly one cycle: the load moves to MEM and the bubble is in EX.
  - Next cycle the consumer enters EX and receives fwd sel 2 from WB.
- Register-file write-in-WB / read-in-ID collisions (producer three ahead) are resolved inside the register file. This block does not forward them.
- stall_count: increments by 1 on each edge where stall=1; saturates at all-ones (no wrap).
- Latency:
  - fwd selects and stall are valid in the same cycle as the state/inputs they depend on (zero-cycle combinational).
  - Stage shift: one cycle.

Test Plan:
1. Reset mid-stall: assert rst_n=0 while stall=1 -> immediately stall=0, fwd_a_sel=fwd_b_sel=0, stall_count=0. After release, the first instruction flows normally.
2. EX/MEM forward: issue add r3 (reg_write, rd=3), then sub rs=3, rt=4 on the next cycle. When sub is in EX -> fwd_a_sel=1, fwd_b_sel=0.
3. MEM/WB forward and priority:
   - Issue r5 writer, unrelated op, then reader rs=5 -> fwd_a_sel=2.
   - Issue two back-to-back writers of r5, then reader rs=5, rt=5 -> fwd_a_sel=fwd_b_sel=1.
4. Load-use: load rd=7, next ID has rt=7, uses_rt=1 -> stall=1 for exactly one cycle and EX gets a bubble. Next cycle: fwd_b_sel=2, stall_count increments 0->1.
5. Register zero / flush:
   - Writer rd=0 followed by reader rs=0 -> fwd_a_sel=0.
   - Load rd=9 with ID reader of r9 and flush=1 -> stall=0, EX bubble, and no forwarding the following cycle.
6. Counter saturation: with CNT_W=4, hold a load-use pattern repeatedly for 20 stall cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects and load-use stall generation,
// driven by a private shadow of the EX/MEM/WB destination information.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } ex_stage_t;

  // MEM and WB only ever act as producers, so only producer fields are kept.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } dst_stage_t;

  ex_stage_t  ex_q, ex_d;
  dst_stage_t mem_q, wb_q;

  function automatic logic produces(input dst_stage_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic [1:0] sel_for(input ex_stage_t ex, input dst_stage_t mem,
                                         input dst_stage_t wb, input logic [REG_ADDR_W-1:0] src,
                                         input logic uses);
    if (!ex.valid || !uses) return 2'd0;
    if (produces(mem, src)) return 2'd1;
    if (produces(wb, src))  return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    stall = id_valid && !flush && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
            ((id_uses_rs && (id_rs == ex_q.rd)) || (id_uses_rt && (id_rt == ex_q.rd)));
    fwd_a_sel = sel_for(ex_q, mem_q, wb_q, ex_q.rs, ex_q.uses_rs);
    fwd_b_sel = sel_for(ex_q, mem_q, wb_q, ex_q.rt, ex_q.uses_rt);
  end

  always_comb begin
    ex_d.valid     = id_valid;
    ex_d.rs        = id_rs;
    ex_d.rt        = id_rt;
    ex_d.uses_rs   = id_uses_rs;
    ex_d.uses_rt   = id_uses_rt;
    ex_d.rd        = id_rd;
    ex_d.reg_write = id_reg_write;
    ex_d.mem_read  = id_mem_read;
    if (stall || flush) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      wb_q  <= mem_q;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
